dmem_access_ctrl: RTL and testbench

- Sequences the MEM stage's access to a variable-latency data memory over a req/ready handshake.
- Stalls all upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM) while an access is in flight.
- Feeds MEM/WB a gated register-write enable plus the returned read data.
- Detects memory timeouts, and counts stall cycles and completed accesses for performance analysis.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/perf_counter.sv | 24 ++
 rtl/dmem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared MEM-stage types and constants
package pipe_pkg;

   typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ABORT} mem_state_t;

   localparam int DMEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - enable / synchronous-clear performance counter
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count enabled cycles; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage sequencer for a variable-latency data memory
module dmem_access_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = DMEM_TIMEOUT_DEF,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             reg_write_in,
   input  logic [31:0]      address,
   input  logic [31:0]      write_data,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [31:0]      dmem_addr,
   output logic [31:0]      dmem_wdata,
   input  logic [31:0]      dmem_rdata,
   input  logic             dmem_ready,
   output logic             stall,
   output logic             mwb_reg_write,
   output logic [31:0]      mwb_read_data,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] access_cnt
);

   localparam int WC_W = $clog2(TIMEOUT) + 1;

   mem_state_t        state_q, state_d;
   logic [31:0]       lat_addr_q;
   logic [31:0]       lat_wdata_q;
   logic              lat_we_q;
   logic              lat_regw_q;
   logic [WC_W-1:0]   wait_cnt_q;
   logic [WC_W-1:0]   wait_inc;
   logic              err_q;
   logic              access;
   logic              complete;
   logic              start_wait;

   assign access     = mem_read | mem_write;
   assign wait_inc   = wait_cnt_q + WC_W'(1);
   assign start_wait = (state_q == MEM_IDLE) && access && !dmem_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. The request cycle in IDLE already counts as the
   // first cycle without ready, so the post-increment count is compared
   // to give TIMEOUT stall cycles in total before aborting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE:  if (start_wait) state_d = MEM_WAIT;
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = MEM_IDLE;
            end else if (wait_inc == WC_W'(TIMEOUT - 1)) begin
               state_d = MEM_ABORT;
            end
         end
         MEM_ABORT: state_d = MEM_IDLE;
         default:   state_d = MEM_IDLE;
      endcase
   end

   // Request latches, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_we_q    <= 1'b0;
         lat_regw_q  <= 1'b0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         if (start_wait) begin
            lat_addr_q  <= address;
            lat_wdata_q <= write_data;
            lat_we_q    <= mem_write;
            lat_regw_q  <= reg_write_in;
            wait_cnt_q  <= '0;
         end else if (state_q == MEM_WAIT && !dmem_ready) begin
            wait_cnt_q  <= wait_inc;
         end
         if (state_q == MEM_ABORT) begin
            err_q <= 1'b1;
         end
      end
   end

   // Output muxing; reset forces an idle, non-stalling, non-writing cycle.
   always_comb begin
      dmem_req      = 1'b0;
      dmem_we       = lat_we_q;
      dmem_addr     = lat_addr_q;
      dmem_wdata    = lat_wdata_q;
      stall         = 1'b0;
      mwb_reg_write = 1'b0;
      mwb_read_data = '0;
      complete      = 1'b0;
      if (!rst) begin
         case (state_q)
            MEM_IDLE: begin
               dmem_req   = access;
               dmem_we    = mem_write;
               dmem_addr  = address;
               dmem_wdata = write_data;
               if (access) begin
                  if (dmem_ready) begin
                     mwb_read_data = dmem_rdata;
                     mwb_reg_write = reg_write_in;
                     complete      = 1'b1;
                  end else begin
                     stall = 1'b1;
                  end
               end else begin
                  mwb_reg_write = reg_write_in;
               end
            end
            MEM_WAIT: begin
               dmem_req = 1'b1;
               if (dmem_ready) begin
                  mwb_read_data = dmem_rdata;
                  mwb_reg_write = lat_regw_q;
                  complete      = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign err = err_q;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (stall),
      .cnt_o (stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_access_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (complete),
      .cnt_o (access_cnt)
   );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write_in;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        stall;
   logic        mwb_reg_write;
   logic [31:0] mwb_read_data;
   logic        err;
   logic [31:0] stall_cnt;
   logic [31:0] access_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string       nm;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        stl;
      logic        rw;
      logic [31:0] rd;
      logic        er;
      logic [31:0] sc;
      logic [31:0] ac;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   dmem_access_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write_in  (reg_write_in),
      .address       (address),
      .write_data    (write_data),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ready    (dmem_ready),
      .stall         (stall),
      .mwb_reg_write (mwb_reg_write),
      .mwb_read_data (mwb_read_data),
      .err           (err),
      .stall_cnt     (stall_cnt),
      .access_cnt    (access_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
      end
   endtask

   task automatic drive(input logic r, input logic rd_i, input logic wr_i, input logic rwi,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rdy, input logic [31:0] rdat);
      rst          = r;
      mem_read     = rd_i;
      mem_write    = wr_i;
      reg_write_in = rwi;
      address      = a;
      write_data   = wd;
      dmem_ready   = rdy;
      dmem_rdata   = rdat;
   endtask

   task automatic expect_cyc(input string nm, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic stl, input logic rw, input logic [31:0] rd,
                             input logic er, input logic [31:0] sc, input logic [31:0] ac);
      exp_t x;
      x.nm = nm; x.req = req; x.we = we; x.addr = addr; x.wd = wd;
      x.stl = stl; x.rw = rw; x.rd = rd; x.er = er; x.sc = sc; x.ac = ac;
      exp_q.push_back(x);
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected record per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         cmp({mon_e.nm, ".req"},   {31'b0, dmem_req},      {31'b0, mon_e.req});
         cmp({mon_e.nm, ".stall"}, {31'b0, stall},         {31'b0, mon_e.stl});
         cmp({mon_e.nm, ".mwb_rw"},{31'b0, mwb_reg_write}, {31'b0, mon_e.rw});
         cmp({mon_e.nm, ".mwb_rd"}, mwb_read_data,         mon_e.rd);
         cmp({mon_e.nm, ".err"},   {31'b0, err},           {31'b0, mon_e.er});
         cmp({mon_e.nm, ".stall_cnt"},  stall_cnt,         mon_e.sc);
         cmp({mon_e.nm, ".access_cnt"}, access_cnt,        mon_e.ac);
         if (mon_e.req) begin
            cmp({mon_e.nm, ".we"},    {31'b0, dmem_we},    {31'b0, mon_e.we});
            cmp({mon_e.nm, ".addr"},  dmem_addr,           mon_e.addr);
            cmp({mon_e.nm, ".wdata"}, dmem_wdata,          mon_e.wd);
         end
      end
   end

   initial begin
      drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      next_cyc();
      next_cyc();

      // Reset cycle gates every output even with a ready load presented.
      drive(1, 1, 0, 1, 32'h40, 32'h0, 1, 32'h55);
      expect_cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();

      // ALU instruction, stray ready ignored.
      drive(0, 0, 0, 1, 32'h10, 32'h0, 1, 32'h99);
      expect_cyc("alu", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      next_cyc();

      // Zero-wait load.
      drive(0, 1, 0, 1, 32'h40, 32'h0, 1, 32'hDEADBEEF);
      expect_cyc("ld0w", 1, 0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0, 0);
      next_cyc();

      // Store with 3 wait cycles; inputs change during the wait.
      drive(0, 0, 1, 0, 32'h80, 32'h12345678, 0, 32'h0);
      expect_cyc("st_a", 1, 1, 32'h80, 32'h12345678, 1, 0, 0, 0, 0, 1);
      next_cyc();
      drive(0, 1, 0, 1, 32'hFF, 32'h0, 0, 32'h0);
      expect_cyc("st_b", 1, 1, 32'h80, 32'h12345678, 1, 0, 0, 0, 1, 1);
      next_cyc();
      drive(0, 1, 0, 1, 32'hFF, 32'h0, 0, 32'h0);
      expect_cyc("st_c", 1, 1, 32'h80, 32'h12345678, 1, 0, 0, 0, 2, 1);
      next_cyc();
      drive(0, 1, 0, 1, 32'hFF, 32'h0, 1, 32'hAAAA0000);
      expect_cyc("st_d", 1, 1, 32'h80, 32'h12345678, 0, 0, 32'hAAAA0000, 0, 3, 1);
      next_cyc();

      // Back-to-back loads, one wait cycle each.
      drive(0, 1, 0, 1, 32'h100, 32'h0, 0, 32'h0);
      expect_cyc("bb1_a", 1, 0, 32'h100, 32'h0, 1, 0, 0, 0, 3, 2);
      next_cyc();
      drive(0, 1, 0, 1, 32'h100, 32'h0, 1, 32'h11111111);
      expect_cyc("bb1_b", 1, 0, 32'h100, 32'h0, 0, 1, 32'h11111111, 0, 4, 2);
      next_cyc();
      drive(0, 1, 0, 1, 32'h104, 32'h0, 0, 32'h0);
      expect_cyc("bb2_a", 1, 0, 32'h104, 32'h0, 1, 0, 0, 0, 4, 3);
      next_cyc();
      drive(0, 1, 0, 1, 32'h104, 32'h0, 1, 32'h22222222);
      expect_cyc("bb2_b", 1, 0, 32'h104, 32'h0, 0, 1, 32'h22222222, 0, 5, 3);
      next_cyc();

      // Timeout: 16 stall cycles, then one abort cycle.
      drive(0, 1, 0, 1, 32'h200, 32'h0, 0, 32'h0);
      expect_cyc("to_req", 1, 0, 32'h200, 32'h0, 1, 0, 0, 0, 5, 4);
      next_cyc();
      for (int k = 1; k <= 15; k++) begin
         drive(0, 1, 0, 1, 32'h200, 32'h0, 0, 32'h0);
         expect_cyc($sformatf("to_wait%0d", k), 1, 0, 32'h200, 32'h0, 1, 0, 0, 0,
                    32'(5 + k), 4);
         next_cyc();
      end
      drive(0, 1, 0, 1, 32'h200, 32'h0, 0, 32'h0);
      expect_cyc("to_abort", 0, 0, 0, 0, 0, 0, 0, 0, 21, 4);
      next_cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      expect_cyc("to_after", 0, 0, 0, 0, 0, 0, 0, 1, 21, 4);
      next_cyc();
      drive(0, 1, 0, 1, 32'h44, 32'h0, 1, 32'h33);
      expect_cyc("err_sticky", 1, 0, 32'h44, 32'h0, 0, 1, 32'h33, 1, 21, 4);
      next_cyc();

      // Reset on the second wait cycle of a load.
      drive(0, 1, 0, 1, 32'h300, 32'h0, 0, 32'h0);
      expect_cyc("rst_a", 1, 0, 32'h300, 32'h0, 1, 0, 0, 1, 21, 5);
      next_cyc();
      drive(1, 1, 0, 1, 32'h300, 32'h0, 0, 32'h0);
      expect_cyc("rst_b", 0, 0, 0, 0, 0, 0, 0, 1, 22, 5);
      next_cyc();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h77);
      expect_cyc("rst_c", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();
      drive(0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h77);
      expect_cyc("rst_d", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      next_cyc();

      drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         next_cyc();
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
